// File: rtl/adder_pipe_nbit_pkg.sv
// Shared types for the pipelined add/subtract unit: operation mode,
// per-stage control record and carry/borrow helper functions.
package adder_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_t;

  // Control part of one pipeline stage; data fields live in the top level
  // because their widths depend on the module parameters.
  typedef struct packed {
    logic  valid;
    mode_t mode;
    logic  carry;
  } stage_rec_t;

  localparam int DEFAULT_NUM_BITS   = 16;
  localparam int DEFAULT_NUM_STAGES = 4;

  // Carry fed into chunk 0: subtraction adds ~b plus the inverted borrow.
  function automatic logic stage_cin(input mode_t m, input logic carry_in);
    return (m == SUB) ? !carry_in : carry_in;
  endfunction

  // Carry out of the top chunk is a carry for ADD and a "no borrow" for SUB.
  function automatic logic final_overflow(input mode_t m, input logic cout);
    return (m == SUB) ? !cout : cout;
  endfunction

endpackage

// File: rtl/adder_pipe_nbit_if.sv
// Valid/ready stream bundle for adder_pipe_nbit: operands in, result out.
interface adder_pipe_nbit_if
  import adder_pkg::*;
#(
  parameter int NUM_BITS = DEFAULT_NUM_BITS
) ();

  logic                in_valid;
  logic                in_ready;
  logic [NUM_BITS-1:0] a;
  logic [NUM_BITS-1:0] b;
  logic                carry_in;
  mode_t               mode;
  logic                out_valid;
  logic                out_ready;
  logic [NUM_BITS-1:0] sum;
  logic                overflow;

  // Producer/consumer side that feeds operands and takes results.
  modport master (
    output in_valid, a, b, carry_in, mode, out_ready,
    input  in_ready, out_valid, sum, overflow
  );

  // The adder itself.
  modport slave (
    input  in_valid, a, b, carry_in, mode, out_ready,
    output in_ready, out_valid, sum, overflow
  );

endinterface

// File: rtl/adder_pipe_nbit_stage.sv
// One chunk of the pipelined adder: a + (b or ~b) + cin with carry out.
module adder_pipe_stage #(
  parameter int CHUNK_BITS = 4
) (
  input  logic [CHUNK_BITS-1:0] a_c,
  input  logic [CHUNK_BITS-1:0] b_c,
  input  logic                  cin,
  input  logic                  sub,
  output logic [CHUNK_BITS-1:0] sum_c,
  output logic                  cout
);

  logic [CHUNK_BITS-1:0] b_eff;
  logic [CHUNK_BITS:0]   total;

  // Chunk add with optional inversion of B for subtraction.
  always_comb begin
    b_eff = sub ? ~b_c : b_c;
    total = {1'b0, a_c} + {1'b0, b_eff} + {{CHUNK_BITS{1'b0}}, cin};
    sum_c = total[CHUNK_BITS-1:0];
    cout  = total[CHUNK_BITS];
  end

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined NUM_BITS add/subtract: one CHUNK_BITS slice per stage, carry
// registered between stages, whole pipe advances together (global stall).
// Optional macro ADDER_PIPE_SAT_EN: saturate the final sum on carry/borrow.
module adder_pipe_nbit
  import adder_pkg::*;
#(
  parameter int NUM_BITS   = DEFAULT_NUM_BITS,
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) (
  input  logic             clk,
  input  logic             n_rst,
  adder_pipe_nbit_if.slave bus
);

  localparam int CHUNK_BITS = NUM_BITS / NUM_STAGES;
  localparam int LAST       = NUM_STAGES - 1;

  if (NUM_BITS % NUM_STAGES != 0) begin : g_bad_cfg
    $error("adder_pipe_nbit: NUM_BITS must be a multiple of NUM_STAGES");
  end

  // Stage registers; operand copies carry the not-yet-added chunks forward.
  stage_rec_t          rec_q [NUM_STAGES];
  stage_rec_t          rec_d [NUM_STAGES];
  logic [NUM_BITS-1:0] res_q [NUM_STAGES];
  logic [NUM_BITS-1:0] res_d [NUM_STAGES];
  logic [NUM_BITS-1:0] opa_q [NUM_STAGES];
  logic [NUM_BITS-1:0] opa_d [NUM_STAGES];
  logic [NUM_BITS-1:0] opb_q [NUM_STAGES];
  logic [NUM_BITS-1:0] opb_d [NUM_STAGES];

  // What each stage sees at its input: bus for stage 0, previous stage else.
  stage_rec_t          src_rec [NUM_STAGES];
  logic [NUM_BITS-1:0] src_a   [NUM_STAGES];
  logic [NUM_BITS-1:0] src_b   [NUM_STAGES];
  logic [NUM_BITS-1:0] src_res [NUM_STAGES];

  logic [CHUNK_BITS-1:0] sum_c  [NUM_STAGES];
  logic                  cout_c [NUM_STAGES];
  logic                  adv;

  assign adv           = !rec_q[LAST].valid || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = rec_q[LAST].valid;
  assign bus.sum       = res_q[LAST];
  assign bus.overflow  = final_overflow(rec_q[LAST].mode, rec_q[LAST].carry);

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign src_rec[gi] = '{valid: bus.in_valid, mode: bus.mode,
                             carry: stage_cin(bus.mode, bus.carry_in)};
      assign src_a[gi]   = bus.a;
      assign src_b[gi]   = bus.b;
      assign src_res[gi] = '0;
    end else begin : g_body
      assign src_rec[gi] = rec_q[gi-1];
      assign src_a[gi]   = opa_q[gi-1];
      assign src_b[gi]   = opb_q[gi-1];
      assign src_res[gi] = res_q[gi-1];
    end

    adder_pipe_stage #(
      .CHUNK_BITS(CHUNK_BITS)
    ) u_stage (
      .a_c  (src_a[gi][gi*CHUNK_BITS +: CHUNK_BITS]),
      .b_c  (src_b[gi][gi*CHUNK_BITS +: CHUNK_BITS]),
      .cin  (src_rec[gi].carry),
      .sub  (src_rec[gi].mode == SUB),
      .sum_c(sum_c[gi]),
      .cout (cout_c[gi])
    );
  end

  // Next stage contents: previous results plus this stage's chunk.
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      rec_d[k] = '{valid: src_rec[k].valid, mode: src_rec[k].mode, carry: cout_c[k]};
      opa_d[k] = src_a[k];
      opb_d[k] = src_b[k];
      res_d[k] = src_res[k];
      res_d[k][k*CHUNK_BITS +: CHUNK_BITS] = sum_c[k];
    end
`ifdef ADDER_PIPE_SAT_EN
    // Clamp to all-ones on ADD carry and to zero on SUB borrow.
    if (final_overflow(src_rec[LAST].mode, cout_c[LAST])) begin
      res_d[LAST] = (src_rec[LAST].mode == ADD) ? '1 : '0;
    end
`endif
  end

  // Whole pipeline advances together; a stalled output freezes every stage.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        rec_q[k] <= '{valid: 1'b0, mode: ADD, carry: 1'b0};
        res_q[k] <= '0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        rec_q[k] <= rec_d[k];
        res_q[k] <= res_d[k];
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Scoreboard bench for adder_pipe_nbit: stimulus pushes model results on
// accept, a negedge monitor pops and compares on every output transfer.
module tb_adder_pipe_nbit;
  import adder_pkg::*;

  localparam int NB = 16;
  localparam int NS = 4;

  typedef struct {
    logic [NB-1:0] sum;
    logic          ovf;
    int            acc_cyc;
    int            acc_stall;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  adder_pipe_nbit_if #(.NUM_BITS(NB)) bus ();

  adder_pipe_nbit #(
    .NUM_BITS  (NB),
    .NUM_STAGES(NS)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus.slave)
  );

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  int            ncyc = 0;
  int            stall_total = 0;
  logic          prev_stalled = 1'b0;
  logic [NB-1:0] prev_sum;
  logic          prev_ovf;
  logic          rand_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, ncyc);
    end
  endtask

  // Reference: full-width arithmetic straight from the add/sub rules.
  function automatic void model(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                input logic cin, input mode_t m,
                                output logic [NB-1:0] s, output logic o);
    logic [NB:0] t;
    if (m == ADD) t = {1'b0, a} + {1'b0, b} + {{NB{1'b0}}, cin};
    else          t = {1'b0, a} - {1'b0, b} - {{NB{1'b0}}, cin};
    s = t[NB-1:0];
    o = t[NB];
`ifdef ADDER_PIPE_SAT_EN
    if (o) s = (m == ADD) ? {NB{1'b1}} : {NB{1'b0}};
`endif
  endfunction

  // Monitor / scoreboard: handshakes are sampled at negedge, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (!n_rst) begin
      sb.delete();
      prev_stalled = 1'b0;
    end else begin
      check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (prev_stalled) begin
        check("stall_valid_held", bus.out_valid, 1'b1);
        check("stall_sum_stable", bus.sum, prev_sum);
        check("stall_ovf_stable", bus.overflow, prev_ovf);
      end
      if (bus.out_valid && !bus.out_ready) stall_total++;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual sum=%0h required=no output (cycle %0d)",
                   bus.sum, ncyc);
        end else begin
          e = sb.pop_front();
          check("sum", bus.sum, e.sum);
          check("overflow", bus.overflow, e.ovf);
          check("latency", ncyc - e.acc_cyc, NS + (stall_total - e.acc_stall));
          $display("out: sum=%04h ovf=%0b lat=%0d", bus.sum, bus.overflow, ncyc - e.acc_cyc);
        end
      end
      prev_stalled = bus.out_valid && !bus.out_ready;
      prev_sum     = bus.sum;
      prev_ovf     = bus.overflow;
      if (bus.in_valid && bus.in_ready) begin
        model(bus.a, bus.b, bus.carry_in, bus.mode, e.sum, e.ovf);
        e.acc_cyc   = ncyc;
        e.acc_stall = stall_total;
        sb.push_back(e);
        $display("in : a=%04h b=%04h cin=%0b mode=%s exp=%04h/%0b",
                 bus.a, bus.b, bus.carry_in, bus.mode.name(), e.sum, e.ovf);
      end
    end
  end

  // Offer one transfer (entered and left at posedge+1), then scramble inputs.
  task automatic send(input logic [NB-1:0] a, input logic [NB-1:0] b,
                      input logic cin, input mode_t m);
    int   t = 0;
    logic ok;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.carry_in = cin;
    bus.mode     = m;
    while (1) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      t++;
      if (t > 100) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=no accept required=accept within 100 cycles");
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.a        = NB'($urandom);
    bus.b        = NB'($urandom);
    bus.carry_in = 1'($urandom);
    bus.mode     = mode_t'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.carry_in  = 1'b0;
    bus.mode      = ADD;
    bus.out_ready = 1'b1;
    rand_done     = 1'b0;
    n_rst         = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_sum", bus.sum, 0);
    check("reset_overflow", bus.overflow, 1'b0);
    check("reset_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // Directed vectors including chunk-boundary carries and borrows
    send(16'hFFFF, 16'h0001, 1'b0, ADD);
    send(16'h00FF, 16'h0001, 1'b1, ADD);
    send(16'h0005, 16'h0007, 1'b0, SUB);
    send(16'h1234, 16'h0234, 1'b0, SUB);
    send(16'h8000, 16'h8000, 1'b0, ADD);
    send(16'h0000, 16'h0000, 1'b1, SUB);
    drain();

    // Back-to-back stream with an output stall of four cycles
    fork
      begin
        for (int i = 0; i < 8; i++) send(NB'(i), NB'(i), 1'b0, ADD);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Mid-flight reset must flush everything in the pipe
    fork
      begin
        for (int i = 0; i < 3; i++) send(16'h1111 * NB'(i + 1), 16'h0101, 1'b0, ADD);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
      end
    join
    for (int i = 0; i < NS + 4; i++) begin
      @(negedge clk);
      check("flushed_no_valid", bus.out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    send(16'h4321, 16'h1234, 1'b1, ADD);
    drain();

    // Random traffic with random backpressure and idle gaps
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send(NB'($urandom), NB'($urandom), 1'($urandom),
               mode_t'($urandom_range(0, 1)));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adder_pipe_nbit.md
Name: adder_pipe_nbit

Overview:
Parameterised, pipelined add/subtract unit, successor to the single-cycle ripple-carry adder.
- Splits NUM_BITS operands into NUM_STAGES equal chunks and adds one chunk per stage.
- Carry is registered between stages, so the critical path is one chunk wide.
- Valid/ready handshake on both sides, so it sits between streaming datapath blocks (e.g. accumulator, FIR tap summation).

Parameters:
NUM_BITS, 16, operand/result width; NUM_BITS % NUM_STAGES must equal 0 (elaboration $error otherwise).
NUM_STAGES, 4, pipeline depth and chunk count; CHUNK_BITS = NUM_BITS/NUM_STAGES; 1 allowed (single-register adder).

Ports:
clk  input  1  single clock; all state updates on rising edge.
n_rst  input  1  synchronous, active-low reset; sampled on rising clk only.
in_valid  input  1  operands/mode/carry_in valid this cycle.
in_ready  output  1  block accepts input this cycle.
a  input  NUM_BITS  operand A.
b  input  NUM_BITS  operand B.
carry_in  input  1  carry in for ADD; borrow in for SUB.
mode  input  1  adder_pkg::mode_t: ADD=0, SUB=1.
out_valid  output  1  sum/overflow valid.
out_ready  input  1  downstream accepts result.
sum  output  NUM_BITS  result.
overflow  output  1  ADD: unsigned carry out; SUB: borrow out.

Behaviour:
- Global advance: adv = !out_valid || out_ready. in_ready = adv. Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
- Stage k (0..NUM_STAGES-1) holds: valid bit, mode, carry bit, result chunks 0..k done, and remaining operand chunks k+1.. skewed forward unchanged.
- Stage 0 computes chunk 0 from inputs on an accepted transfer. Stage k computes chunk k from stage k-1's held operands and registered carry.
- Arithmetic:
  - ADD: chunk = a_c + b_c + cin.
  - SUB: chunk = a_c + ~b_c + cin', where stage-0 cin' = !carry_in.
  - Final overflow: ADD = carry out of top chunk; SUB = !(carry out of top chunk).
  - Results are modulo 2^NUM_BITS.
- Latency: NUM_STAGES cycles from accept to out_valid with no stall. Throughput is 1 result/cycle.
- Stall: when adv=0 every stage register holds (valid bits included). No bubbles are inserted or dropped, and data is never lost or duplicated.
- Bubbles: when adv=1, a stage with no incoming valid data loads valid=0. Data fields of invalid stages are don't-care but must not be X-propagated into valid results.
- sum and overflow are driven from the last stage registers. They must stay stable while out_valid && !out_ready.
- Reset (n_rst=0 at edge): all valid bits=0, sum=0, overflow=0, carries=0. During reset in_ready = 1 (out_valid=0), but any input presented is discarded.
  - Mid-operation reset flushes all in-flight results; none may appear afterwards.
- Simultaneous out transfer and in transfer in the same cycle is legal and must not lose data.
- Mode and carry_in are captured at accept; changing them afterwards has no effect on in-flight data.

Optional Feature:
ADDER_PIPE_SAT_EN:
- Defined: final stage saturates. ADD with overflow gives sum = all-ones; SUB with borrow gives sum = 0. overflow still reports the raw carry/borrow.
- Undefined: wrap-around modulo 2^NUM_BITS, no saturation logic synthesised.

Decomposition:
Package adder_pkg:
- typedef enum logic {ADD, SUB} mode_t.
- Stage-record struct typedef (valid, mode, carry), parameterised via module-local widths.
Sub-module adder_pipe_stage (params CHUNK_BITS):
- Combinational chunk add with carry in/out and conditional B inversion.
- Instanced NUM_STAGES times in a generate loop. Registers live in the top level.

Test Plan (NUM_BITS=16, NUM_STAGES=4, out_ready=1 unless noted):
- ADD 0xFFFF+0x0001, cin=0 -> after 4 cycles out_valid=1, sum=0x0000, overflow=1 (SAT_EN: sum=0xFFFF).
- ADD 0x00FF+0x0001, cin=1 -> sum=0x0101, overflow=0 (carry ripples across chunk 1/2 via pipeline regs).
- SUB 0x0005-0x0007, borrow_in=0 -> sum=0xFFFE, overflow=1 (SAT_EN: 0x0000). SUB 0x1234-0x0234 -> 0x1000, overflow=0.
- 8 back-to-back ADDs (i+i, i=0..7) with out_ready low cycles 3-6 -> results 0,2,...,14 in order, none lost or duplicated; in_ready low exactly while output is stalled.
- Issue 3 transfers, assert n_rst low 1 cycle at cycle 2 -> out_valid never rises for those 3; next input after reset returns the correct sum after 4 cycles.
- NUM_STAGES=1 build: 0x8000+0x8000 -> sum=0x0000, overflow=1, latency 1 cycle.
